multi_timer: RTL and testbench
==============================

# multi_timer

Parametrised multi-channel countdown timer for the alarm controller, and the successor to the single-channel seconds timer. It runs CHANNELS independent second-resolution countdowns, such as the entry delay, the exit delay and the siren duration. Each channel is WIDTH bits wide and supports one-shot or auto-reload mode, pause, and abort. Shared 1 Hz and blink enables are generated once, for the main FSM and the siren.

## Interface
- CHANNELS, 4: number of independent countdown channels (≥1).
- WIDTH, 4: bits of each seconds counter; max load 2^WIDTH−1.
- CLK_HZ, 100_000_000: clock cycles per second; must be even and ≥2.
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  CHANNELS  per-channel load pulse; load value and begin counting.
- value  in  CHANNELS*WIDTH  load values; channel i at [i*WIDTH +: WIDTH].
- stop  in  CHANNELS  per-channel abort to IDLE.
- pause  in  CHANNELS  per-channel level; freezes count and phase while high.
- reload_mode  in  CHANNELS  1 = auto-reload at terminal count; 0 = one-shot.
- count  out  CHANNELS*WIDTH  remaining seconds per channel, for the display.
- active  out  CHANNELS  channel state is RUNNING.
- expired  out  CHANNELS  level; count == 0.
- done_pulse  out  CHANNELS  one-cycle pulse at terminal count.
- one_hz_enable  out  1  global one-cycle strobe, once every CLK_HZ cycles.
- half_hz_enable  out  1  global blink square wave; toggles every CLK_HZ/2 cycles.

## Operation
- Each channel has the following registers:
  - state: IDLE, RUNNING or EXPIRED.
  - count (WIDTH bits).
  - load latch (WIDTH bits), holding the last loaded value.
  - phase counter, $clog2(CLK_HZ) bits, range 0..CLK_HZ−1.
- Per-channel command priority, evaluated each edge: stop > start > count.
  - stop: state=IDLE, count=0, phase=0.
  - start: latch value; count=value; phase=0.
    - If value ≠ 0: state=RUNNING.
    - If value = 0: state=EXPIRED and done_pulse asserted.
    - Start while RUNNING restarts the channel; start while EXPIRED reloads it.
  - Counting happens only in RUNNING with pause=0.
    - If phase < CLK_HZ−1: phase+1.
    - Otherwise: phase=0 and count−1.
- Terminal count: count is 1 and the phase wraps.
  - One-shot: count=0, state=EXPIRED, done_pulse asserted.
  - Auto-reload: count=latch, phase=0, stays RUNNING, done_pulse asserted, expired stays 0.
- Width rules:
  - count never wraps below 0.
  - value·2 is not needed; no multiplication anywhere.
- The global prescaler is free-running and independent of the channels.
  - Counter runs 0..CLK_HZ−1.
  - one_hz_enable is high for the cycle after the counter reaches CLK_HZ−1.
  - half_hz_enable toggles at counter CLK_HZ/2−1 and at CLK_HZ−1.

## Timing
- Reset (reset_n=0), asynchronous:
  - count=0, expired=all 1, active=0, done_pulse=0.
  - one_hz_enable=0, half_hz_enable=0.
  - All states IDLE; phases and prescaler at 0.
- Reset mid-count aborts every channel immediately; no done_pulse is produced.
- start sampled at edge k, value=N (N ≠ 0):
  - count=N and active=1 after edge k.
  - count=N−j after edge k+j·CLK_HZ.
  - count=0, expired=1 and done_pulse=1 after edge k+N·CLK_HZ, for exactly one cycle.
- Pause of P cycles (pause=1 sampled at P edges) delays every later event by exactly P cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package timer_pkg holds:
  - the state encoding constants: IDLE=2'd0, RUNNING=2'd1, EXPIRED=2'd2;
  - the default CLK_HZ;
  - the phase-width helper.
- Sub-module timer_channel holds one channel's state, latch, phase and count.
  - The top instantiates it CHANNELS times in a generate loop.
  - The top holds the global prescaler and blink logic.

## Test plan
Use CLK_HZ=10, CHANNELS=4, WIDTH=4 throughout.
- Reset:
  - Stimulus: assert reset_n=0 asynchronously between edges.
  - Required: outputs go to reset values at once; expired=4'b1111, count=0.
  - Stimulus: release reset_n.
  - Required: one_hz_enable pulses every 10 cycles; half_hz_enable toggles every 5 cycles.
- One-shot:
  - Stimulus: start[0] with value 3 at edge k.
  - Required: count 3, 2, 1, 0 after edges k, k+10, k+20, k+30.
  - Required: done_pulse[0] high for exactly 1 cycle after k+30; expired[0] rises together with it.
- Auto-reload:
  - Stimulus: reload_mode[1]=1, start with value 2.
  - Required: count sequence 2, 1, 2, 1 with steps every 10 cycles.
  - Required: done_pulse[1] every 20 cycles; expired[1] stays 0; active[1] stays 1.
- Pause:
  - Stimulus: start[2] with value 2, then pause[2]=1 for 15 cycles starting at k+4.
  - Required: done_pulse[2] after edge k+35; count holds at 2 while paused.
- Priority and edge cases:
  - Stimulus: start[3] and stop[3] at the same edge.
  - Required: IDLE, count 0.
  - Stimulus: start with value 0.
  - Required: done_pulse the next cycle, expired=1, active=0.
  - Stimulus: restart at k+15 while running with value 3.
  - Required: expiry at k+45.
- Independence:
  - Stimulus: run all 4 channels with different values.
  - Required: each channel is unaffected by the others.
  - Stimulus: reset_n=0 mid-count.
  - Required: all channels abort with no done_pulse.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel countdown timer: channel state encoding,
// default clock rate and the phase-counter width helper.
package timer_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRunning = 2'd1,
    StExpired = 2'd2
  } timer_state_e;

  localparam int unsigned DefaultClkHz = 100_000_000;

  // Bits needed to hold a phase value in 0..clk_hz-1.
  function automatic int unsigned phase_width(input int unsigned clk_hz);
    return (clk_hz > 1) ? $clog2(clk_hz) : 1;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: state, load latch, sub-second phase and seconds count.
// Command priority each edge is stop > start > count.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned CLK_HZ = DefaultClkHz
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             pause_i,
  input  logic             reload_mode_i,
  input  logic [WIDTH-1:0] value_i,
  output logic [WIDTH-1:0] count_o,
  output logic             active_o,
  output logic             expired_o,
  output logic             done_pulse_o
);

  localparam int unsigned PhaseW = phase_width(CLK_HZ);
  localparam logic [PhaseW-1:0] PhaseMax = PhaseW'(CLK_HZ - 1);

  timer_state_e      state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  latch_q, latch_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic              done_q, done_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      count_q <= '0;
      latch_q <= '0;
      phase_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      latch_q <= latch_d;
      phase_q <= phase_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    latch_d = latch_q;
    phase_d = phase_q;
    done_d  = 1'b0;
    if (stop_i) begin
      state_d = StIdle;
      count_d = '0;
      phase_d = '0;
    end else if (start_i) begin
      latch_d = value_i;
      count_d = value_i;
      phase_d = '0;
      if (value_i != '0) begin
        state_d = StRunning;
      end else begin
        state_d = StExpired;
        done_d  = 1'b1;
      end
    end else if (state_q == StRunning && !pause_i) begin
      if (phase_q != PhaseMax) begin
        phase_d = phase_q + PhaseW'(1);
      end else begin
        phase_d = '0;
        // Terminal count is the wrap while count is 1; a zero count never decrements.
        if (count_q == WIDTH'(1)) begin
          done_d = 1'b1;
          if (reload_mode_i) begin
            count_d = latch_q;
          end else begin
            count_d = '0;
            state_d = StExpired;
          end
        end else if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    count_o      = count_q;
    active_o     = (state_q == StRunning);
    expired_o    = (count_q == '0);
    done_pulse_o = done_q;
  end

endmodule

// File: rtl/multi_timer.sv
// Multi-channel seconds countdown timer with a shared free-running 1 Hz strobe
// and blink square wave.
module multi_timer
  import timer_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CLK_HZ   = DefaultClkHz
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [CHANNELS-1:0]       start_i,
  input  logic [CHANNELS*WIDTH-1:0] value_i,
  input  logic [CHANNELS-1:0]       stop_i,
  input  logic [CHANNELS-1:0]       pause_i,
  input  logic [CHANNELS-1:0]       reload_mode_i,
  output logic [CHANNELS*WIDTH-1:0] count_o,
  output logic [CHANNELS-1:0]       active_o,
  output logic [CHANNELS-1:0]       expired_o,
  output logic [CHANNELS-1:0]       done_pulse_o,
  output logic                      one_hz_enable_o,
  output logic                      half_hz_enable_o
);

  localparam int unsigned PhaseW = phase_width(CLK_HZ);
  localparam logic [PhaseW-1:0] PreMax  = PhaseW'(CLK_HZ - 1);
  localparam logic [PhaseW-1:0] HalfMax = PhaseW'(CLK_HZ / 2 - 1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    timer_channel #(
      .WIDTH  (WIDTH),
      .CLK_HZ (CLK_HZ)
    ) u_chan (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .start_i       (start_i[i]),
      .stop_i        (stop_i[i]),
      .pause_i       (pause_i[i]),
      .reload_mode_i (reload_mode_i[i]),
      .value_i       (value_i[i*WIDTH +: WIDTH]),
      .count_o       (count_o[i*WIDTH +: WIDTH]),
      .active_o      (active_o[i]),
      .expired_o     (expired_o[i]),
      .done_pulse_o  (done_pulse_o[i])
    );
  end

  logic [PhaseW-1:0] pre_q, pre_d;
  logic              one_hz_q, one_hz_d;
  logic              half_q, half_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q    <= '0;
      one_hz_q <= 1'b0;
      half_q   <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      one_hz_q <= one_hz_d;
      half_q   <= half_d;
    end
  end

  always_comb begin
    pre_d    = (pre_q == PreMax) ? '0 : pre_q + PhaseW'(1);
    one_hz_d = (pre_q == PreMax);
    half_d   = (pre_q == PreMax || pre_q == HalfMax) ? ~half_q : half_q;
  end

  assign one_hz_enable_o  = one_hz_q;
  assign half_hz_enable_o = half_q;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: deadline-based reference model checked every cycle,
// plus hand-computed literal checkpoints.
module tb_multi_timer;

  localparam int CH = 4;
  localparam int W  = 4;
  localparam int HZ = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [CH-1:0]   start = '0, stop = '0, pause = '0, reload = '0;
  logic [CH*W-1:0] value = '0;
  logic [CH*W-1:0] count;
  logic [CH-1:0]   active, expired, done;
  logic            one_hz, half_hz;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  multi_timer #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .CLK_HZ   (HZ)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .start_i          (start),
    .value_i          (value),
    .stop_i           (stop),
    .pause_i          (pause),
    .reload_mode_i    (reload),
    .count_o          (count),
    .active_o         (active),
    .expired_o        (expired),
    .done_pulse_o     (done),
    .one_hz_enable_o  (one_hz),
    .half_hz_enable_o (half_hz)
  );

  // Reference model: each running channel has an absolute deadline edge for its next
  // one-second step; every paused edge pushes the deadline out by one.
  int      n;
  int      m_cnt[CH];
  int      m_st[CH];   // 0 idle, 1 running, 2 expired
  int      m_latch[CH];
  int      m_dl[CH];
  bit      m_done[CH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0;
      for (int i = 0; i < CH; i++) begin
        m_cnt[i] = 0; m_st[i] = 0; m_latch[i] = 0; m_dl[i] = 0; m_done[i] = 0;
      end
    end else begin
      n++;
      for (int i = 0; i < CH; i++) begin
        m_done[i] = 0;
        if (stop[i]) begin
          m_st[i] = 0;
          m_cnt[i] = 0;
        end else if (start[i]) begin
          m_latch[i] = int'(value[i*W +: W]);
          m_cnt[i] = m_latch[i];
          m_dl[i] = n + HZ;
          if (m_cnt[i] != 0) m_st[i] = 1;
          else begin
            m_st[i] = 2;
            m_done[i] = 1;
          end
        end else if (m_st[i] == 1) begin
          if (pause[i]) m_dl[i]++;
          else if (n == m_dl[i]) begin
            m_dl[i] += HZ;
            if (m_cnt[i] == 1) begin
              m_done[i] = 1;
              if (reload[i]) m_cnt[i] = m_latch[i];
              else begin
                m_cnt[i] = 0;
                m_st[i] = 2;
              end
            end else begin
              m_cnt[i]--;
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      logic [CH*W-1:0] e_cnt;
      logic [CH-1:0]   e_act, e_exp, e_done;
      for (int i = 0; i < CH; i++) begin
        e_cnt[i*W +: W] = W'(m_cnt[i]);
        e_act[i]  = (m_st[i] == 1);
        e_exp[i]  = (m_cnt[i] == 0);
        e_done[i] = m_done[i];
      end
      check("model count", 32'(count), 32'(e_cnt));
      check("model active", 32'(active), 32'(e_act));
      check("model expired", 32'(expired), 32'(e_exp));
      check("model done_pulse", 32'(done), 32'(e_done));
      check("model one_hz", 32'(one_hz), 32'(n > 0 && n % HZ == 0));
      check("model half_hz", 32'(half_hz), 32'((n / (HZ / 2)) % 2));
    end
  end

  function automatic logic [W-1:0] ch_cnt(input int i);
    return count[i*W +: W];
  endfunction

  task automatic wait_n(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic go_start(input int ch, input logic [W-1:0] v);
    value[ch*W +: W] = v;
    start[ch] = 1'b1;
    @(negedge clk);
    start[ch] = 1'b0;
  endtask

  initial begin
    // Asynchronous reset between edges.
    #3 rst_n = 1'b0;
    #1;
    check("rst count", 32'(count), 32'h0);
    check("rst expired", 32'(expired), 32'hF);
    check("rst active", 32'(active), 32'h0);
    check("rst done", 32'(done), 32'h0);
    check("rst one_hz/half", {30'd0, one_hz, half_hz}, 32'h0);
    wait_n(2);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Prescaler from release.
    wait_n(5);
    check("half_hz after 5", 32'(half_hz), 32'h1);
    check("one_hz after 5", 32'(one_hz), 32'h0);
    wait_n(5);
    check("one_hz after 10", 32'(one_hz), 32'h1);
    check("half_hz after 10", 32'(half_hz), 32'h0);
    wait_n(1);
    check("one_hz after 11", 32'(one_hz), 32'h0);

    // One-shot on channel 0.
    go_start(0, 4'd3);
    check("os k count", 32'(ch_cnt(0)), 32'd3);
    check("os k active", 32'(active[0]), 32'h1);
    wait_n(10);
    check("os k+10 count", 32'(ch_cnt(0)), 32'd2);
    wait_n(10);
    check("os k+20 count", 32'(ch_cnt(0)), 32'd1);
    wait_n(9);
    check("os k+29 done", 32'(done[0]), 32'h0);
    wait_n(1);
    check("os k+30 count", 32'(ch_cnt(0)), 32'd0);
    check("os k+30 done", 32'(done[0]), 32'h1);
    check("os k+30 expired", 32'(expired[0]), 32'h1);
    wait_n(1);
    check("os k+31 done", 32'(done[0]), 32'h0);

    // Auto-reload on channel 1.
    reload[1] = 1'b1;
    go_start(1, 4'd2);
    check("ar k count", 32'(ch_cnt(1)), 32'd2);
    wait_n(10);
    check("ar k+10 count", 32'(ch_cnt(1)), 32'd1);
    wait_n(10);
    check("ar k+20 count", 32'(ch_cnt(1)), 32'd2);
    check("ar k+20 done", 32'(done[1]), 32'h1);
    check("ar k+20 expired", 32'(expired[1]), 32'h0);
    check("ar k+20 active", 32'(active[1]), 32'h1);
    wait_n(10);
    check("ar k+30 count", 32'(ch_cnt(1)), 32'd1);
    wait_n(10);
    check("ar k+40 done", 32'(done[1]), 32'h1);
    stop[1] = 1'b1;
    @(negedge clk);
    stop[1] = 1'b0;
    reload[1] = 1'b0;
    check("ar stop active", 32'(active[1]), 32'h0);
    check("ar stop count", 32'(ch_cnt(1)), 32'd0);

    // Pause on channel 2: 15 paused edges k+4..k+18.
    go_start(2, 4'd2);
    wait_n(3);
    pause[2] = 1'b1;
    wait_n(15);
    pause[2] = 1'b0;
    check("pz k+18 count", 32'(ch_cnt(2)), 32'd2);
    wait_n(16);
    check("pz k+34 done", 32'(done[2]), 32'h0);
    check("pz k+34 count", 32'(ch_cnt(2)), 32'd1);
    wait_n(1);
    check("pz k+35 done", 32'(done[2]), 32'h1);
    check("pz k+35 count", 32'(ch_cnt(2)), 32'd0);

    // Stop beats start; zero load expires at once.
    value[3*W +: W] = 4'd7;
    start[3] = 1'b1;
    stop[3] = 1'b1;
    @(negedge clk);
    start[3] = 1'b0;
    stop[3] = 1'b0;
    check("prio count", 32'(ch_cnt(3)), 32'd0);
    check("prio active", 32'(active[3]), 32'h0);
    go_start(3, 4'd0);
    check("zero done", 32'(done[3]), 32'h1);
    check("zero expired", 32'(expired[3]), 32'h1);
    check("zero active", 32'(active[3]), 32'h0);

    // Restart at k+15 with 3 -> expiry at k+45.
    go_start(0, 4'd2);
    wait_n(14);
    go_start(0, 4'd3);
    check("rs k+15 count", 32'(ch_cnt(0)), 32'd3);
    wait_n(29);
    check("rs k+44 done", 32'(done[0]), 32'h0);
    wait_n(1);
    check("rs k+45 done", 32'(done[0]), 32'h1);

    // Independence: all channels, distinct loads.
    value = 16'h4321;
    start = 4'hF;
    @(negedge clk);
    start = 4'h0;
    check("ind k count", 32'(count), 32'h4321);
    wait_n(10);
    check("ind k+10 count", 32'(count), 32'h3210);
    check("ind k+10 done", 32'(done), 32'h1);
    wait_n(10);
    check("ind k+20 count", 32'(count), 32'h2100);
    check("ind k+20 done", 32'(done), 32'h2);
    wait_n(5);

    // Reset mid-count aborts everything.
    @(posedge clk);
    #3 rst_n = 1'b0;
    chk_en = 1'b0;
    #1;
    check("mid rst count", 32'(count), 32'h0);
    check("mid rst active", 32'(active), 32'h0);
    check("mid rst expired", 32'(expired), 32'hF);
    check("mid rst done", 32'(done), 32'h0);
    wait_n(2);
    check("mid rst hold done", 32'(done), 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    wait_n(40);
    check("post rst active", 32'(active), 32'h0);
    check("post rst count", 32'(count), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
